// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state encoding and sizing helpers for the sequential multiplier
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int N_DEFAULT = 32;
  localparam int CNT_W_DEFAULT = $clog2(N_DEFAULT);

  // Iteration counter width for an N-bit operand: counts 0..N-1.
  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/cla_Nbit.sv
// rtl/cla_Nbit.sv - W-bit generate/propagate adder, carry-out not exported
module cla_Nbit #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);

  logic [W-1:0] p;
  logic [W-1:0] c;

  assign p = a ^ b;

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 1; i < W; i++) begin
      c[i] = (a[i-1] & b[i-1]) | (p[i-1] & c[i-1]);
    end
  end

  assign sum = p ^ c;

endmodule

// File: rtl/mult_seq_gen.sv
// rtl/mult_seq_gen.sv - shift-and-add multiplier, signed/unsigned, optional early termination
module mult_seq_gen
  import mult_pkg::*;
#(
  parameter int N          = 32,
  parameter int EARLY_TERM = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   multiplier,
  input  logic [N-1:0]   multiplicand,
  input  logic           abort,
  output logic           ready,
  output logic [2*N-1:0] product,
  output logic           valid
);

  localparam int CW = cnt_width(N);

  state_e         state;
  logic [N-1:0]   mplier;
  logic [2*N-1:0] mcand;
  logic [2*N-1:0] acc;
  logic           neg;
  logic [CW-1:0]  cnt;

  logic [N-1:0]   mp_mag;
  logic [N-1:0]   mc_mag;
  logic [2*N-1:0] add_a;
  logic [2*N-1:0] add_b;
  logic [2*N-1:0] sum;
  logic           last_iter;

  // -2^(N-1) negates to itself, which read as unsigned is the correct magnitude.
  assign mp_mag = (signed_mode && multiplier[N-1])   ? -multiplier   : multiplier;
  assign mc_mag = (signed_mode && multiplicand[N-1]) ? -multiplicand : multiplicand;

  // FIN reuses the adder for ~acc + 1; RUN uses it for the partial-product add.
  assign add_a = (state == FIN) ? ~acc : acc;
  assign add_b = (state == FIN) ? {{(2*N-1){1'b0}}, 1'b1} : mcand;

  cla_Nbit #(.W(2*N)) u_add (
    .a   (add_a),
    .b   (add_b),
    .cin (1'b0),
    .sum (sum)
  );

  assign last_iter = (cnt == CW'(N-1)) ||
                     ((EARLY_TERM != 0) && (mplier[N-1:1] == '0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      mplier  <= '0;
      mcand   <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      cnt     <= '0;
      product <= '0;
      valid   <= 1'b0;
      ready   <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mplier <= mp_mag;
            mcand  <= {{N{1'b0}}, mc_mag};
            neg    <= signed_mode & (multiplier[N-1] ^ multiplicand[N-1]);
            acc    <= '0;
            cnt    <= '0;
            valid  <= 1'b0;
            ready  <= 1'b0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            valid <= 1'b0;
            ready <= 1'b1;
            state <= IDLE;
          end else begin
            if (mplier[0]) acc <= sum;
            mplier <= mplier >> 1;
            mcand  <= mcand << 1;
            cnt    <= cnt + CW'(1);
            if (last_iter) state <= FIN;
          end
        end
        FIN: begin
          if (abort) begin
            valid <= 1'b0;
            ready <= 1'b1;
            state <= IDLE;
          end else begin
            product <= neg ? sum : acc;
            valid   <= 1'b1;
            ready   <= 1'b1;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_gen.sv
// tb/tb_mult_seq_gen.sv - self-checking bench for mult_seq_gen (N=8, early and full termination)
module tb_mult_seq_gen;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic           signed_mode = 1'b0;
  logic           abort = 1'b0;
  logic [N-1:0]   multiplier = '0;
  logic [N-1:0]   multiplicand = '0;
  logic           ready, valid, ready_f, valid_f;
  logic [2*N-1:0] product, product_f;

  always #5 clk = ~clk;

  mult_seq_gen #(.N(N), .EARLY_TERM(1)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
    .multiplier(multiplier), .multiplicand(multiplicand), .abort(abort),
    .ready(ready), .product(product), .valid(valid)
  );

  mult_seq_gen #(.N(N), .EARLY_TERM(0)) dut_full (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
    .multiplier(multiplier), .multiplicand(multiplicand), .abort(abort),
    .ready(ready_f), .product(product_f), .valid(valid_f)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] last_p = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_prod(input logic [7:0] mc, input logic [7:0] mp, input logic sm);
    int a, b;
    a = (sm && mc[7]) ? int'(mc) - 256 : int'(mc);
    b = (sm && mp[7]) ? int'(mp) - 256 : int'(mp);
    return 16'(a * b);
  endfunction

  function automatic int model_lat(input logic [7:0] mp, input logic sm, input bit early);
    int mag, k;
    if (!early) return N + 1;
    mag = (sm && mp[7]) ? 256 - int'(mp) : int'(mp);
    k = 0;
    while ((mag >> k) != 0) k++;
    return ((k < 1) ? 1 : k) + 1;
  endfunction

  task automatic run_op(input logic [7:0] mc, input logic [7:0] mp, input logic sm,
                        output int lat, output int lat_f,
                        output logic [15:0] p, output logic [15:0] p_f);
    @(negedge clk);
    start = 1'b1; multiplicand = mc; multiplier = mp; signed_mode = sm;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("valid_drop", {valid, valid_f}, 2'b00);
    lat = 0; lat_f = 0; p = '0; p_f = '0;
    for (int e = 1; e <= 2 * N + 4; e++) begin
      @(posedge clk); #1;
      if (lat == 0 && valid) begin lat = e; p = product; end
      if (lat_f == 0 && valid_f) begin lat_f = e; p_f = product_f; end
      if (lat != 0 && lat_f != 0) break;
    end
  endtask

  task automatic op_check(input string name, input logic [7:0] mc, input logic [7:0] mp,
                          input logic sm, input logic [15:0] exp_p, input int exp_lat);
    int lat, lat_f;
    logic [15:0] p, p_f;
    run_op(mc, mp, sm, lat, lat_f, p, p_f);
    check({name, "_prod"}, p, exp_p);
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_prod_full"}, p_f, exp_p);
    check({name, "_lat_full"}, lat_f, N + 1);
    last_p = exp_p;
  endtask

  typedef struct {
    logic [7:0]  mc;
    logic [7:0]  mp;
    logic        sm;
    logic [15:0] exp_p;
    int          exp_lat;
  } vec_t;

  vec_t vt[8];

  initial begin
    int lat, lat_f, e;
    logic [15:0] p, p_f, exp;
    logic [7:0] mc, mp;
    logic sm;

    vt[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, 9};
    vt[1] = '{8'h80, 8'h80, 1'b1, 16'h4000, 9};
    vt[2] = '{8'hFD, 8'h05, 1'b1, 16'hFFF1, 4};
    vt[3] = '{8'hFD, 8'h00, 1'b1, 16'h0000, 2};
    vt[4] = '{8'h0C, 8'h0C, 1'b0, 16'h0090, 5};
    vt[5] = '{8'hC8, 8'h03, 1'b0, 16'h0258, 3};
    vt[6] = '{8'h7F, 8'h80, 1'b1, 16'hC080, 9};
    vt[7] = '{8'h01, 8'h01, 1'b1, 16'h0001, 2};

    #12;
    check("reset_ready", {ready, ready_f}, 2'b11);
    check("reset_valid", {valid, valid_f}, 2'b00);
    check("reset_product", product, 16'h0);
    check("reset_product_full", product_f, 16'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      op_check($sformatf("vec%0d", i), vt[i].mc, vt[i].mp, vt[i].sm, vt[i].exp_p, vt[i].exp_lat);
    end

    // Start pulse with different operands during RUN must be ignored.
    @(negedge clk);
    start = 1'b1; multiplicand = 8'd7; multiplier = 8'd9; signed_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; multiplicand = 8'hFF; multiplier = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; lat_f = 0; p = '0; p_f = '0;
    for (e = 3; e <= 2 * N + 4; e++) begin
      @(posedge clk); #1;
      if (lat == 0 && valid) begin lat = e; p = product; end
      if (lat_f == 0 && valid_f) begin lat_f = e; p_f = product_f; end
      if (lat != 0 && lat_f != 0) break;
    end
    check("run_start_prod", p, 16'd63);
    check("run_start_lat", lat, 5);
    check("run_start_prod_full", p_f, 16'd63);
    check("run_start_lat_full", lat_f, 9);
    last_p = 16'd63;

    // Abort in DONE is ignored.
    abort = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("done_abort_valid", {valid, valid_f}, 2'b11);
    check("done_abort_prod", product, last_p);
    check("done_abort_ready", {ready, ready_f}, 2'b11);

    // Abort on the 3rd RUN cycle.
    @(negedge clk);
    start = 1'b1; multiplicand = 8'd7; multiplier = 8'd9; signed_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_ready", {ready, ready_f}, 2'b11);
    check("abort_valid", {valid, valid_f}, 2'b00);
    check("abort_prod", product, last_p);
    check("abort_prod_full", product_f, last_p);
    @(posedge clk); #1;
    check("abort_idle_hold", {ready, valid}, 2'b10);

    // Start and abort together in DONE: start wins.
    op_check("pre_done", 8'd5, 8'd6, 1'b0, 16'd30, 4);
    abort = 1'b1;
    op_check("start_abort", 8'hF6, 8'h0B, 1'b1, 16'hFF92, 5);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: mp = 8'h00;
        1: mp = 8'h80;
        default: mp = 8'($urandom);
      endcase
      mc = ($urandom_range(0, 5) == 0) ? 8'h80 : 8'($urandom);
      sm = 1'($urandom_range(0, 1));
      exp = model_prod(mc, mp, sm);
      op_check($sformatf("rnd%0d", i), mc, mp, sm, exp, model_lat(mp, sm, 1'b1));
    end

    // Asynchronous reset mid-RUN.
    @(negedge clk);
    start = 1'b1; multiplicand = 8'd100; multiplier = 8'd200; signed_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("rst_run_ready", {ready, ready_f}, 2'b11);
    check("rst_run_valid", {valid, valid_f}, 2'b00);
    check("rst_run_prod", product, 16'h0);
    check("rst_run_prod_full", product_f, 16'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    op_check("post_rst", 8'd100, 8'd200, 1'b0, 16'h4E20, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mult_seq_gen.md
MULT_SEQ_GEN -- requirements
Module: mult_seq_gen

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter N, default 32: operand width, legal range 4..64.
REQ-002 The block SHALL have parameter EARLY_TERM, default 1: 1 enables early termination when the remaining multiplier bits are zero.
Ports (name, direction, width, meaning):
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a new operation; accepted only when ready=1.
REQ-006 signed_mode  input  1  1 selects two's-complement operands, 0 selects unsigned; sampled with start.
REQ-007 multiplier  input  N  operand; sampled on the accepting edge.
REQ-008 multiplicand  input  N  operand; sampled on the accepting edge.
REQ-009 abort  input  1  cancels an operation in progress.
REQ-010 ready  output  1  high in IDLE and DONE.
REQ-011 product  output  2N  registered result.
REQ-012 valid  output  1  product holds the result of the last completed operation.

Function
REQ-013 The FSM SHALL have four states: IDLE, RUN, FIN, DONE.
REQ-014 start with ready=1 SHALL load the magnitude of each operand, record the result sign (XOR of operand MSBs when signed_mode=1, else 0), clear the accumulator and iteration counter, drop valid, and go to RUN.
- In signed mode the magnitude of -2^(N-1) is 2^(N-1) as an N-bit unsigned value.
REQ-015 Each RUN cycle SHALL perform one iteration:
- if the multiplier LSB is 1, accumulator <= accumulator + multiplicand, computed with a 2N-bit add, carry-out discarded;
- multiplier shifts right by 1, zero-fill;
- multiplicand shifts left by 1, zero-fill;
- counter increments.
REQ-016 RUN SHALL exit to FIN after the iteration in which the counter reaches N-1 or, when EARLY_TERM=1, after the iteration that leaves the shifted multiplier equal to zero.
REQ-017 RUN cycle count SHALL be N when EARLY_TERM=0, and max(1,k) when EARLY_TERM=1, where k is 1 + the index of the highest set bit of |multiplier|.
REQ-018 FIN SHALL write product <= accumulator, or its two's-complement negation when the result sign is 1, set valid=1, and go to DONE.
REQ-019 Latency SHALL be: valid rises at the (RUN cycles + 1)th rising edge after the accepting edge.
REQ-020 In DONE, product and valid SHALL hold until the next accepted start; start in DONE behaves as in IDLE (back-to-back operations).
REQ-021 start in RUN or FIN SHALL be ignored.
REQ-022 abort in RUN or FIN SHALL force IDLE on the next edge with valid=0 and product unchanged.
REQ-023 abort in IDLE or DONE SHALL be ignored.
REQ-024 If abort and start are asserted together in DONE, start wins.
REQ-025 Signed results SHALL be exact over the full range, e.g. (-2^(N-1))*(-2^(N-1)) = 2^(2N-2) with no overflow.

Reset
REQ-026 While reset=0, the state SHALL be IDLE and all registers SHALL be 0: product=0, valid=0, ready=1.
REQ-027 Reset asserted mid-operation SHALL discard the operation immediately, asynchronously.
REQ-028 The first start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-029 A shared package mult_pkg SHALL hold:
- the FSM state enum;
- the counter-width constant, computed as $clog2(N).
REQ-030 The 2N-bit adder SHALL be the existing team module cla_Nbit instantiated with width 2N and cin=0; it is the only sub-module.
REQ-031 The two's-complement negation in FIN SHALL reuse the same cla_Nbit instance via an operand mux, not a second adder.

Verification
REQ-032 With N=8, unsigned, EARLY_TERM=1: 255*255 -> product 0xFE01, valid 9 edges after start.
REQ-033 With N=8, signed: -128 * -128 -> product 0x4000, valid 9 edges after start.
REQ-034 With N=8, signed: multiplicand=-3, multiplier=5 -> product 0xFFF1, valid 4 edges after start; multiplier=0 -> product 0, valid 2 edges after start.
REQ-035 With N=8: start 7*9, then abort on the 3rd RUN cycle -> IDLE next edge, valid=0, product retains its prior value; a start pulse during RUN is ignored.
REQ-036 Back-to-back and reset cases:
- two operations, 12*12 then unsigned 200*3, with start asserted in DONE -> 0x0090 then 0x0258, each flagged by valid;
- reset pulled low mid-RUN -> product=0, valid=0, ready=1 immediately.
